// File: rtl/wb_ram_bist.sv
// Wishbone RAM self-test master: writes seed+i to word i, reads back and compares.
// Optional ack watchdog enabled by defining WB_RAM_BIST_TIMEOUT_EN.
module wb_ram_bist #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH-1:0]   word_count,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic                    wbm_we_o,
  output logic [SELECT_WIDTH-1:0] wbm_sel_o,
  output logic                    wbm_stb_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  output logic                    wbm_cyc_o
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_FINISH} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d, count_q, count_d, idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d, first_q, first_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]        errs_q, errs_d;
  logic we_q, we_d, stb_q, stb_d, cyc_q, cyc_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, abort_q, abort_d;

  logic                  tmo_hit;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] word_adr;
  logic [DATA_WIDTH-1:0] word_pat;

  assign last_word = (idx_q == count_q - ADDR_WIDTH'(1));
  assign word_adr  = base_q + idx_q * ADDR_WIDTH'(SELECT_WIDTH);
  assign word_pat  = seed_q + DATA_WIDTH'(idx_q);

`ifdef WB_RAM_BIST_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts cycles a strobe has waited without any slave response.
  always_comb begin
    tmo_d = '0;
    if (stb_q && !wbm_ack_i && !wbm_err_i) tmo_d = tmo_q + TMO_W'(1);
  end
  assign tmo_hit = stb_q && !wbm_ack_i && !wbm_err_i &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    seed_d  = seed_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;
    errs_d  = errs_q;
    first_d = first_q;
    abort_d = abort_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = word_count;
          seed_d  = seed;
          idx_d   = '0;
          errs_d  = '0;
          first_d = '0;
          abort_d = 1'b0;
          if (word_count == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_WRITE;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            adr_d   = base_addr;
            dat_d   = seed;
            sel_d   = '1;
          end
        end
      end
      ST_WRITE, ST_READ: begin
        if (stb_q && (wbm_err_i || tmo_hit)) begin
          // Bus error wins over a simultaneous ack.
          state_d = ST_FINISH;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          abort_d = 1'b1;
        end else if (stb_q && wbm_ack_i) begin
          stb_d = 1'b0;
          if (state_q == ST_READ && wbm_dat_i != word_pat) begin
            if (errs_q == '0) first_d = adr_q;
            if (errs_q != {CNT_W{1'b1}}) errs_d = errs_q + CNT_W'(1);
          end
          if (!last_word) begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end else if (state_q == ST_WRITE) begin
            state_d = ST_READ;
            idx_d   = '0;
            we_d    = 1'b0;
          end else begin
            state_d = ST_FINISH;
            cyc_d   = 1'b0;
          end
        end else if (!stb_q) begin
          // One idle cycle after each ack, then present the next word.
          stb_d = 1'b1;
          adr_d = word_adr;
          dat_d = (state_q == ST_WRITE) ? word_pat : '0;
          sel_d = '1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
    if (state_d == ST_FINISH && state_q != ST_FINISH)
      pass_d = (errs_d == '0) && !abort_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      count_q <= '0;
      seed_q  <= '0;
      idx_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      errs_q  <= '0;
      first_q <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      seed_q  <= seed_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      errs_q  <= errs_d;
      first_q <= first_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = errs_q;
  assign first_err_addr = first_q;
  assign wbm_adr_o      = adr_q;
  assign wbm_dat_o      = dat_q;
  assign wbm_we_o       = we_q;
  assign wbm_sel_o      = sel_q;
  assign wbm_stb_o      = stb_q;
  assign wbm_cyc_o      = cyc_q;

endmodule

// File: tb/tb_wb_ram_bist.sv
// Self-checking bench for wb_ram_bist: behavioural Wishbone RAM slave plus
// scoreboards of expected bus transfers and expected test results.
module tb_wb_ram_bist;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned SW = DW / 8;

  logic          clk, rst_n, start;
  logic [AW-1:0] base_addr, word_count;
  logic [DW-1:0] seed;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr, wbm_adr_o;
  logic [DW-1:0] wbm_dat_o, wbm_dat_i;
  logic          wbm_we_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_cyc_o;
  logic [SW-1:0] wbm_sel_o;

  wb_ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .wbm_cyc_o(wbm_cyc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic we; logic [AW-1:0] adr; logic [DW-1:0] dat; } xfer_t;
  typedef struct { logic pass; logic [15:0] errs; logic [AW-1:0] first; } res_t;

  xfer_t xq[$];
  res_t  rq[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural RAM slave with registered ack, optional error and ack withholding.
  logic [DW-1:0] mem [0:(1<<(AW-2))-1];
  int  wr_seen = 0;
  int  err_at  = 0;
  bit  hold    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm_ack_i <= 1'b0;
      wbm_err_i <= 1'b0;
      wbm_dat_i <= '0;
    end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i && !hold) begin
      if (wbm_we_o) begin
        wr_seen <= wr_seen + 1;
        if (err_at != 0 && wr_seen + 1 == err_at) begin
          wbm_err_i <= 1'b1;
        end else begin
          wbm_ack_i <= 1'b1;
          mem[wbm_adr_o[AW-1:2]] <= wbm_dat_o;
        end
      end else begin
        wbm_ack_i <= 1'b1;
        wbm_dat_i <= mem[wbm_adr_o[AW-1:2]];
      end
    end else begin
      wbm_ack_i <= 1'b0;
      wbm_err_i <= 1'b0;
    end
  end

  // Bus monitor: each completed transfer is checked against the expected queue.
  bit prev_xfer = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_xfer <= 1'b0;
    end else begin
      if (prev_xfer) check_eq("stb_gap", 64'(wbm_stb_o), 64'd0);
      prev_xfer <= wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i);
      if (wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i)) begin
        if (xq.size() == 0) begin
          check_eq("xfer_extra", 64'(wbm_adr_o), 64'hFFFF_FFFF);
        end else begin
          xfer_t e;
          e = xq.pop_front();
          check_eq("xfer_we",  64'(wbm_we_o),  64'(e.we));
          check_eq("xfer_adr", 64'(wbm_adr_o), 64'(e.adr));
          check_eq("xfer_sel", 64'(wbm_sel_o), 64'hF);
          if (e.we) check_eq("xfer_dat", 64'(wbm_dat_o), 64'(e.dat));
        end
      end
    end
  end

  task automatic push_xfers(input logic [AW-1:0] b, input logic [DW-1:0] s, input int n_wr, input int n_rd);
    xfer_t x;
    for (int i = 0; i < n_wr; i++) begin
      x.we = 1'b1; x.adr = AW'(b + AW'(i * SW)); x.dat = DW'(s + DW'(i));
      xq.push_back(x);
    end
    for (int i = 0; i < n_rd; i++) begin
      x.we = 1'b0; x.adr = AW'(b + AW'(i * SW)); x.dat = '0;
      xq.push_back(x);
    end
  endtask

  task automatic run_test(input string name, input logic [AW-1:0] b, input logic [AW-1:0] cnt,
                          input logic [DW-1:0] s, input int n_wr, input int n_rd,
                          input int err_wr, input bit corrupt, input bit poke,
                          input logic e_pass, input logic [15:0] e_errs, input logic [AW-1:0] e_first);
    res_t r;
    int   lat;
    bit   saw_cyc;
    bit   did_corrupt;
    r.pass = e_pass; r.errs = e_errs; r.first = e_first;
    rq.push_back(r);
    push_xfers(b, s, n_wr, n_rd);
    err_at = (err_wr != 0) ? wr_seen + err_wr : 0;
    base_addr = b; word_count = cnt; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; saw_cyc = wbm_cyc_o; did_corrupt = 1'b0;
    while (!done && lat < 3000) begin
      if (corrupt && !did_corrupt && wbm_cyc_o && !wbm_we_o) begin
        mem[16'h0010 >> 2] = 32'hDEADBEEF;
        did_corrupt = 1'b1;
      end
      if (poke && lat == 5) begin
        base_addr = 16'h8000; word_count = 16'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      saw_cyc = saw_cyc | wbm_cyc_o;
    end
    start = 1'b0;
    check_eq({name, "_done"}, 64'(done), 64'd1);
    r = rq.pop_front();
    check_eq({name, "_pass"}, 64'(pass), 64'(r.pass));
    check_eq({name, "_errs"}, 64'(err_count), 64'(r.errs));
    check_eq({name, "_first"}, 64'(first_err_addr), 64'(r.first));
    check_eq({name, "_busy"}, 64'(busy), 64'd1);
    if (cnt == '0) begin
      check_eq({name, "_lat"}, 64'(lat), 64'd1);
      check_eq({name, "_cyc"}, 64'(saw_cyc), 64'd0);
    end
    @(negedge clk);
    check_eq({name, "_done_pulse"}, 64'(done), 64'd0);
    check_eq({name, "_idle"}, 64'(busy), 64'd0);
    check_eq({name, "_cyc_off"}, 64'(wbm_cyc_o), 64'd0);
    check_eq({name, "_xfer_left"}, 64'(xq.size()), 64'd0);
    xq.delete();
    err_at = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w;
    start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_pass", 64'(pass), 64'd0);
    check_eq("rst_cyc",  64'(wbm_cyc_o), 64'd0);
    check_eq("rst_stb",  64'(wbm_stb_o), 64'd0);
    check_eq("rst_errs", 64'(err_count), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_test("basic",   16'h0000, 16'd16, 32'hA5A50000, 16, 16, 0, 1'b0, 1'b0, 1'b1, 16'd0, 16'h0000);
    run_test("corrupt", 16'h0000, 16'd16, 32'hA5A50000, 16, 16, 0, 1'b1, 1'b0, 1'b0, 16'd1, 16'h0010);
    run_test("zero",    16'h1234, 16'd0,  32'h00000000, 0,  0,  0, 1'b0, 1'b0, 1'b1, 16'd0, 16'h0000);
    run_test("wrap",    16'hFFF8, 16'd4,  32'h12345678, 4,  4,  0, 1'b0, 1'b0, 1'b1, 16'd0, 16'h0000);
    run_test("poke",    16'h0100, 16'd5,  32'hFFFFFFFE, 5,  5,  0, 1'b0, 1'b1, 1'b1, 16'd0, 16'h0000);
    run_test("buserr",  16'h0200, 16'd8,  32'h0BADF00D, 3,  0,  3, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000);
`ifdef WB_RAM_BIST_TIMEOUT_EN
    hold = 1'b1;
    run_test("timeout", 16'h0300, 16'd4,  32'h00000001, 0,  0,  0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000);
    hold = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // Reset asserted in the middle of the read phase.
    push_xfers(16'h0400, 32'h00000001, 16, 16);
    base_addr = 16'h0400; word_count = 16'd16; seed = 32'h00000001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(wbm_cyc_o && !wbm_we_o) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check_eq("rst_reach_read", 64'(wbm_cyc_o && !wbm_we_o), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_cyc",  64'(wbm_cyc_o), 64'd0);
    check_eq("midrst_stb",  64'(wbm_stb_o), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    xq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_test("after_rst", 16'h0000, 16'd16, 32'hA5A50000, 16, 16, 0, 1'b0, 1'b0, 1'b1, 16'd0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ram_bist.md
WB_RAM_BIST -- requirements
Module: wb_ram_bist

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, Wishbone byte-address width.
REQ-003 SHALL have parameter SELECT_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, ack watchdog limit; used only when WB_RAM_BIST_TIMEOUT_EN is defined.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle pulse, begins test when idle
- base_addr  in  ADDR_WIDTH  first byte address, SELECT_WIDTH-aligned
- word_count  in  ADDR_WIDTH  number of words tested
- seed  in  DATA_WIDTH  pattern seed
- busy  out  1  test in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  result of last test, held
- err_count  out  16  mismatching words, saturating
- first_err_addr  out  ADDR_WIDTH  byte address of first mismatch
- wbm_adr_o  out  ADDR_WIDTH  Wishbone address
- wbm_dat_o  out  DATA_WIDTH  write data
- wbm_dat_i  in  DATA_WIDTH  read data
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  SELECT_WIDTH  byte select
- wbm_stb_o  out  1  strobe
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  bus error
- wbm_cyc_o  out  1  cycle

Function
REQ-007 SHALL implement states IDLE, WRITE, READ, FINISH.
REQ-008 IDLE: start=1 latches base_addr, word_count, seed, clears err_count, first_err_addr; goes to WRITE, or FINISH if word_count=0; start ignored when busy.
REQ-009 Word i (0..word_count-1) SHALL use address base_addr + i*SELECT_WIDTH (mod 2^ADDR_WIDTH, wrap permitted) and pattern seed + i (mod 2^DATA_WIDTH).
REQ-010 WRITE: writes every word with wbm_we_o=1, wbm_sel_o all ones; after last ack goes to READ.
REQ-011 READ: reads every word with wbm_we_o=0, compares wbm_dat_i to pattern on the ack cycle; after last ack goes to FINISH.
REQ-012 wbm_cyc_o SHALL be 1 throughout WRITE and READ, 0 otherwise.
REQ-013 wbm_stb_o SHALL assert with stable adr/dat/we/sel, hold until ack or err, drop for exactly one cycle after each ack, then assert for next word.
REQ-014 Mismatch: err_count increments (saturates at 16'hFFFF); first mismatch records its address in first_err_addr.
REQ-015 wbm_err_i with stb SHALL abort the test: cyc/stb drop next cycle, go to FINISH, pass=0.
REQ-016 FINISH: one cycle, done=1, pass=1 iff err_count=0 and no abort, then IDLE.
REQ-017 busy SHALL be 1 in WRITE, READ, FINISH.
REQ-018 Simultaneous ack and err SHALL be treated as err.

Reset
REQ-019 rst_n=0 SHALL asynchronously force IDLE and all outputs to 0, including mid-transfer (cyc/stb drop immediately).
REQ-020 Registers SHALL leave reset synchronously on first clk edge after rst_n rises.

Configuration
REQ-021 With WB_RAM_BIST_TIMEOUT_EN defined: a counter runs while stb=1 without ack/err; reaching TIMEOUT_CYCLES aborts as in REQ-015.
REQ-022 Without WB_RAM_BIST_TIMEOUT_EN: no watchdog logic; master waits indefinitely for ack.

Verification
REQ-023 wb_ram_bist driving wb_dp_ram port A; base 0x0000, count 16, seed 0xA5A50000 -> 32 transfers, done pulse, pass=1, err_count=0.
REQ-024 Same, port B writes 0xDEADBEEF to 0x0010 between WRITE and READ phases -> pass=0, err_count=1, first_err_addr=0x0010.
REQ-025 word_count=0 -> no cyc, done one cycle after start, pass=1.
REQ-026 base 0xFFF8, count 4 -> addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004; pass=1.
REQ-027 Slave asserts err on third write -> cyc drops, done, pass=0; with macro, ack withheld 255 cycles -> same abort.
REQ-028 rst_n pulsed low mid-READ -> cyc/stb/busy 0 immediately; new start afterwards completes with pass=1.
